pmu_pwr_seq: RTL and testbench

- 32K-domain power sequencer that drives the clock-enable and reset-request inputs of crgu: osc13m_clk_en, efuse_load_state, timer_clk_en, data_clk_en, slot_clk_en, shut_rstn and pmu_fifo_rstn.
- Runs the efuse load after POR, then parks in SLEEP.
- On rg_top_start it wakes the 13M oscillator, releases the shut-domain resets, then enables clocks.
- Tear-down runs in the reverse order so that resets are always applied with a running clock.

---
 rtl/pmu_pwr_seq.sv | 192 +++++++++++++++++++
 tb/tb_pmu_pwr_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmu_pwr_seq.sv
// pmu_pwr_seq: 32K-domain power sequencer for the crgu clock enables and reset requests.
// After POR it runs the efuse load, then parks in SLEEP. A run request wakes the
// 13M oscillator, releases the shut-domain resets and then opens the clocks.
// Tear-down runs in the reverse order, so resets are always applied while the
// oscillator is still running.
module pmu_pwr_seq #(
  parameter int CNT_W        = 11,
  parameter int EFUSE_TO     = 1024,
  parameter int OSC_SETTLE   = 16,
  parameter int GATE_HOLD    = 2,
  parameter int RST_HOLD     = 2,
  parameter int FIFO_RST_CYC = 2
) (
  input  logic       clk_32k,
  input  logic       rst_32k_alon_n,
  input  logic       rg_top_start,
  input  logic       efuse_done,
  input  logic       fifo_flush_req,
  output logic       osc13m_clk_en,
  output logic       efuse_load_state,
  output logic       timer_clk_en,
  output logic       data_clk_en,
  output logic       slot_clk_en,
  output logic       shut_rstn,
  output logic       pmu_fifo_rstn,
  output logic [2:0] pmu_state,
  output logic       efuse_timeout
);

  typedef enum logic [2:0] {
    ST_EFUSE      = 3'd0,
    ST_SLEEP      = 3'd1,
    ST_WAKE_OSC   = 3'd2,
    ST_REL_RST    = 3'd3,
    ST_RUN        = 3'd4,
    ST_STOP_CLK   = 3'd5,
    ST_ASSERT_RST = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] EFUSE_LAST = CNT_W'(EFUSE_TO - 1);
  localparam logic [CNT_W-1:0] OSC_LAST   = CNT_W'(OSC_SETTLE - 1);
  localparam logic [CNT_W-1:0] GATE_LAST  = CNT_W'(GATE_HOLD - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FIFO_RST_CYC);

  state_e           state_r;
  state_e           state_nxt_s;
  logic             start_meta_r;
  logic             start_s_r;
  logic             done_meta_r;
  logic             done_s_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] flush_cnt_r;
  logic [CNT_W-1:0] flush_cnt_nxt_s;
  logic             timeout_set_s;
  logic             timed_s;
  logic [6:0]       dec_s;

  // Output decode of a state: {osc, efuse_load, timer, data, slot, shut_rstn, fifo_rstn}.
  function automatic logic [6:0] decode_outs(input state_e st);
    logic [6:0] o;
    case (st)
      ST_EFUSE:      o = 7'b1100000;
      ST_SLEEP:      o = 7'b0000000;
      ST_WAKE_OSC:   o = 7'b1000000;
      ST_REL_RST:    o = 7'b1000011;
      ST_RUN:        o = 7'b1011111;
      ST_STOP_CLK:   o = 7'b1000011;
      ST_ASSERT_RST: o = 7'b1000000;
      default:       o = 7'b1000000;
    endcase
    return o;
  endfunction

  // Two-flop synchronisers for the 6.5M-domain level inputs.
  always_ff @(posedge clk_32k) begin
    if (!rst_32k_alon_n) begin
      start_meta_r <= 1'b0;
      start_s_r    <= 1'b0;
      done_meta_r  <= 1'b0;
      done_s_r     <= 1'b0;
    end else begin
      start_meta_r <= rg_top_start;
      start_s_r    <= start_meta_r;
      done_meta_r  <= efuse_done;
      done_s_r     <= done_meta_r;
    end
  end

  // Next-state selection; illegal codes recover through ASSERT_RST.
  always_comb begin
    state_nxt_s   = state_r;
    timeout_set_s = 1'b0;
    case (state_r)
      ST_EFUSE: begin
        if (done_s_r) begin
          state_nxt_s = ST_SLEEP;
        end else if (cnt_r == EFUSE_LAST) begin
          state_nxt_s   = ST_SLEEP;
          timeout_set_s = 1'b1;
        end else begin
          state_nxt_s = ST_EFUSE;
        end
      end
      ST_SLEEP: begin
        if (start_s_r) state_nxt_s = ST_WAKE_OSC;
        else           state_nxt_s = ST_SLEEP;
      end
      ST_WAKE_OSC: begin
        if (!start_s_r)             state_nxt_s = ST_ASSERT_RST;
        else if (cnt_r == OSC_LAST) state_nxt_s = ST_REL_RST;
        else                        state_nxt_s = ST_WAKE_OSC;
      end
      ST_REL_RST: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (!start_s_r) state_nxt_s = ST_STOP_CLK;
        else            state_nxt_s = ST_RUN;
      end
      ST_STOP_CLK: begin
        if (cnt_r == GATE_LAST) state_nxt_s = ST_ASSERT_RST;
        else                    state_nxt_s = ST_STOP_CLK;
      end
      ST_ASSERT_RST: begin
        if (cnt_r == RST_LAST) state_nxt_s = ST_SLEEP;
        else                   state_nxt_s = ST_ASSERT_RST;
      end
      default: begin
        state_nxt_s = ST_ASSERT_RST;
      end
    endcase
  end

  // Shared sequencing counter and FIFO flush counter for the next cycle.
  always_comb begin
    case (state_r)
      ST_EFUSE, ST_WAKE_OSC, ST_STOP_CLK, ST_ASSERT_RST: timed_s = 1'b1;
      default:                                          timed_s = 1'b0;
    endcase

    if (state_nxt_s != state_r) cnt_nxt_s = CNT_ZERO;
    else if (timed_s)           cnt_nxt_s = cnt_r + CNT_ONE;
    else                        cnt_nxt_s = CNT_ZERO;

    // A flush only lives inside RUN; any exit drops it so the state decode rules.
    if ((state_r == ST_RUN) && (state_nxt_s == ST_RUN)) begin
      if (fifo_flush_req)             flush_cnt_nxt_s = FLUSH_LOAD;
      else if (flush_cnt_r != CNT_ZERO) flush_cnt_nxt_s = flush_cnt_r - CNT_ONE;
      else                            flush_cnt_nxt_s = CNT_ZERO;
    end else begin
      flush_cnt_nxt_s = CNT_ZERO;
    end

    dec_s = decode_outs(state_nxt_s);
  end

  // FSM state, counters and glitch-free outputs loaded from the next-state decode.
  always_ff @(posedge clk_32k) begin
    if (!rst_32k_alon_n) begin
      state_r          <= ST_EFUSE;
      cnt_r            <= CNT_ZERO;
      flush_cnt_r      <= CNT_ZERO;
      osc13m_clk_en    <= 1'b0;
      efuse_load_state <= 1'b0;
      timer_clk_en     <= 1'b0;
      data_clk_en      <= 1'b0;
      slot_clk_en      <= 1'b0;
      shut_rstn        <= 1'b0;
      pmu_fifo_rstn    <= 1'b0;
      efuse_timeout    <= 1'b0;
    end else begin
      state_r          <= state_nxt_s;
      cnt_r            <= cnt_nxt_s;
      flush_cnt_r      <= flush_cnt_nxt_s;
      osc13m_clk_en    <= dec_s[6];
      efuse_load_state <= dec_s[5];
      timer_clk_en     <= dec_s[4];
      data_clk_en      <= dec_s[3];
      slot_clk_en      <= dec_s[2];
      shut_rstn        <= dec_s[1];
      pmu_fifo_rstn    <= dec_s[0] & (flush_cnt_nxt_s == CNT_ZERO);
      efuse_timeout    <= efuse_timeout | timeout_set_s;
    end
  end

  assign pmu_state = state_r;

endmodule

// File: tb/tb_pmu_pwr_seq.sv
// tb_pmu_pwr_seq: directed scenarios plus randomized traffic for pmu_pwr_seq,
// checked against a phase/elapsed-time reference model of the sequencer.
module tb_pmu_pwr_seq;

  localparam int EFUSE_TO     = 1024;
  localparam int OSC_SETTLE   = 16;
  localparam int GATE_HOLD    = 2;
  localparam int RST_HOLD     = 2;
  localparam int FIFO_RST_CYC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rg_top_start = 1'b0;
  logic       efuse_done = 1'b0;
  logic       fifo_flush_req = 1'b0;
  logic       osc13m_clk_en, efuse_load_state, timer_clk_en, data_clk_en, slot_clk_en;
  logic       shut_rstn, pmu_fifo_rstn, efuse_timeout;
  logic [2:0] pmu_state;
  logic [10:0] dut_vec;

  int vecs = 0;
  int fails = 0;

  // reference model state
  int          cyc = 0;
  int          m_phase = 0;
  int          m_el = 0;
  logic        m_tout = 1'b0;
  int          m_low_until = 0;
  logic        st_q[$];
  logic        dn_q[$];
  logic [10:0] exp_vec = 11'd0;

  always #5 clk = ~clk;

  pmu_pwr_seq #(
    .CNT_W(11), .EFUSE_TO(EFUSE_TO), .OSC_SETTLE(OSC_SETTLE),
    .GATE_HOLD(GATE_HOLD), .RST_HOLD(RST_HOLD), .FIFO_RST_CYC(FIFO_RST_CYC)
  ) dut (
    .clk_32k(clk), .rst_32k_alon_n(rst_n), .rg_top_start(rg_top_start),
    .efuse_done(efuse_done), .fifo_flush_req(fifo_flush_req),
    .osc13m_clk_en(osc13m_clk_en), .efuse_load_state(efuse_load_state),
    .timer_clk_en(timer_clk_en), .data_clk_en(data_clk_en), .slot_clk_en(slot_clk_en),
    .shut_rstn(shut_rstn), .pmu_fifo_rstn(pmu_fifo_rstn), .pmu_state(pmu_state),
    .efuse_timeout(efuse_timeout)
  );

  assign dut_vec = {osc13m_clk_en, efuse_load_state, timer_clk_en, data_clk_en, slot_clk_en,
                    shut_rstn, pmu_fifo_rstn, efuse_timeout, pmu_state};

  // {osc, efuse_load, timer, data, slot, shut_rstn, fifo_rstn} per phase
  function automatic logic [6:0] phase_outs(input int p);
    case (p)
      0:       return 7'b1100000;
      2, 6:    return 7'b1000000;
      3, 5:    return 7'b1000011;
      4:       return 7'b1011111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Predict what the coming clock edge does, from the inputs currently driven.
  task automatic model_edge();
    logic       s, d;
    int         el, nxt;
    logic [6:0] o;
    cyc++;
    if (rst_n !== 1'b1) begin
      m_phase = 0; m_el = 0; m_tout = 1'b0; m_low_until = 0;
      st_q = {1'b0, 1'b0};
      dn_q = {1'b0, 1'b0};
      exp_vec = 11'd0;
      return;
    end
    // level inputs become visible to the sequencer two samples later
    s = st_q.pop_front(); st_q.push_back(rg_top_start);
    d = dn_q.pop_front(); dn_q.push_back(efuse_done);
    el  = m_el + 1;
    nxt = m_phase;
    case (m_phase)
      0: if (d) nxt = 1; else if (el == EFUSE_TO) begin nxt = 1; m_tout = 1'b1; end
      1: if (s) nxt = 2;
      2: if (!s) nxt = 6; else if (el == OSC_SETTLE) nxt = 3;
      3: nxt = 4;
      4: if (!s) nxt = 5;
      5: if (el == GATE_HOLD) nxt = 6;
      6: if (el == RST_HOLD) nxt = 1;
      default: nxt = 6;
    endcase
    if (m_phase == 4 && nxt == 4 && fifo_flush_req) m_low_until = cyc + FIFO_RST_CYC;
    if (nxt != 4) m_low_until = 0;
    o = phase_outs(nxt);
    if (cyc < m_low_until) o[0] = 1'b0;
    m_el = (nxt != m_phase) ? 0 : el;
    m_phase = nxt;
    exp_vec = {o, m_tout, 3'(m_phase)};
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rg_top_start = 1'b0; efuse_done = 1'b0; fifo_flush_req = 1'b0;
    repeat (3) step();
    vecs++;
    if (dut_vec !== 11'd0) begin
      fails++; $display("FAIL reset_state: got %b want %b", dut_vec, 11'd0);
    end
  endtask

  task automatic test_efuse_done();
    logic [10:0] want;
    rst_n = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      if (e == 20) efuse_done = 1'b1;
      step();
      want = (e < 22) ? 11'b11000000_000 : 11'b00000000_001;
      vecs++;
      if (dut_vec !== want) begin
        fails++; $display("FAIL efuse_done edge %0d: got %b want %b", e, dut_vec, want);
      end
      vecs++;
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL efuse_done_model edge %0d: got %b want %b", e, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_efuse_timeout();
    int exit_e = -1;
    rst_n = 1'b0; efuse_done = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int e = 1; e <= 1100 && exit_e < 0; e++) begin
      step();
      if (efuse_load_state !== 1'b1) exit_e = e;
      vecs++;
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL efuse_to_model edge %0d: got %b want %b", e, dut_vec, exp_vec);
      end
    end
    vecs++;
    if (exit_e != EFUSE_TO) begin
      fails++; $display("FAIL efuse_to_exit: got edge %0d want %0d", exit_e, EFUSE_TO);
    end
    vecs++;
    if (efuse_timeout !== 1'b1 || pmu_state !== 3'd1) begin
      fails++; $display("FAIL efuse_to_flag: got tout=%b state=%0d want tout=1 state=1",
                        efuse_timeout, pmu_state);
    end
    efuse_done = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_wake();
    logic [10:0] want;
    logic        osc, shut, clk_on;
    logic [2:0]  st;
    for (int e = 1; e <= 22; e++) begin
      if (e == 1) rg_top_start = 1'b1;
      step();
      osc    = (e >= 3);
      shut   = (e >= 19);
      clk_on = (e >= 20);
      st     = (e < 3) ? 3'd1 : (e < 19) ? 3'd2 : (e == 19) ? 3'd3 : 3'd4;
      want = {osc, 1'b0, clk_on, clk_on, clk_on, shut, shut, 1'b1, st};
      vecs++;
      if (dut_vec !== want) begin
        fails++; $display("FAIL wake edge %0d: got %b want %b", e, dut_vec, want);
      end
    end
  endtask

  task automatic test_stop();
    logic [10:0] want;
    logic        osc, shut, clk_on;
    logic [2:0]  st;
    for (int e = 1; e <= 9; e++) begin
      if (e == 1) rg_top_start = 1'b0;
      step();
      clk_on = (e < 3);
      shut   = (e < 5);
      osc    = (e < 7);
      st     = (e < 3) ? 3'd4 : (e < 5) ? 3'd5 : (e < 7) ? 3'd6 : 3'd1;
      want = {osc, 1'b0, clk_on, clk_on, clk_on, shut, shut, 1'b1, st};
      vecs++;
      if (dut_vec !== want) begin
        fails++; $display("FAIL stop edge %0d: got %b want %b", e, dut_vec, want);
      end
    end
  endtask

  task automatic test_abort();
    logic [10:0] want;
    logic [2:0]  st;
    for (int e = 1; e <= 14; e++) begin
      if (e == 1) rg_top_start = 1'b1;
      if (e == 7) rg_top_start = 1'b0;
      step();
      st   = (e < 3) ? 3'd1 : (e < 9) ? 3'd2 : (e < 11) ? 3'd6 : 3'd1;
      want = {(e >= 3 && e < 11), 6'b000000, 1'b1, st};
      vecs++;
      if (dut_vec !== want) begin
        fails++; $display("FAIL abort edge %0d: got %b want %b", e, dut_vec, want);
      end
    end
  endtask

  task automatic test_flush();
    int lows = 0;
    rg_top_start = 1'b1;
    repeat (22) step();
    vecs++;
    if (pmu_state !== 3'd4) begin
      fails++; $display("FAIL flush_setup: got state %0d want 4", pmu_state);
    end
    for (int e = 1; e <= 7; e++) begin
      fifo_flush_req = (e == 1 || e == 2);
      step();
      if (pmu_fifo_rstn === 1'b0) lows++;
      vecs++;
      if (pmu_fifo_rstn !== !(e <= 3) ||
          {osc13m_clk_en, timer_clk_en, data_clk_en, slot_clk_en, shut_rstn} !== 5'b11111) begin
        fails++; $display("FAIL flush edge %0d: got %b want fifo_rstn=%b others=1",
                          e, dut_vec, !(e <= 3));
      end
      vecs++;
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL flush_model edge %0d: got %b want %b", e, dut_vec, exp_vec);
      end
    end
    fifo_flush_req = 1'b0;
    vecs++;
    if (lows != 3) begin
      fails++; $display("FAIL flush_len: got %0d low cycles want 3", lows);
    end
    rg_top_start = 1'b0;
    repeat (10) step();
    fifo_flush_req = 1'b1;
    step();
    fifo_flush_req = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      vecs++;
      if (dut_vec[10:4] !== 7'd0 || pmu_state !== 3'd1) begin
        fails++; $display("FAIL flush_in_sleep edge %0d: got %b want outputs 0 state 1", e, dut_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 799) != 0);
      if ($urandom_range(0, 39) == 0) rg_top_start = ~rg_top_start;
      if ($urandom_range(0, 29) == 0) efuse_done = ~efuse_done;
      fifo_flush_req = ($urandom_range(0, 5) == 0);
      step();
      vecs++;
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL random cycle %0d: got %b want %b", i, dut_vec, exp_vec);
      end
    end
    rst_n = 1'b1;
    fifo_flush_req = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_efuse_done();
    test_efuse_timeout();
    test_wake();
    test_stop();
    test_abort();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
